quad_accumulator: RTL and testbench

QUAD_ACCUMULATOR -- requirements
Module: quad_accumulator

---
 rtl/quad_accumulator_pkg.sv | 32 +++
 rtl/quad_accumulator.sv | 97 +++++++++
 tb/tb_quad_accumulator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/quad_accumulator_pkg.sv
// Shared widths, FSM encoding and register bundle for the quad accumulator.
package quad_accumulator_pkg;

  localparam int unsigned C_W = 3;  // bit-count word width
  localparam int unsigned S_W = 5;  // sum width, holds 4*7 = 28
  localparam int unsigned K_W = 3;  // sample counter width, holds 0..4

  typedef enum logic [1:0] {
    WAIT_DAV = 2'd0,
    ACK_IN   = 2'd1,
    PUT_OUT  = 2'd2,
    REL_OUT  = 2'd3
  } state_t;

  // Registered datapath and handshake outputs.
  typedef struct packed {
    logic [S_W-1:0] acc;
    logic [K_W-1:0] k;
    logic [S_W-1:0] s;
    logic           rfd_in;
    logic           dav_out_;
  } regs_t;

  localparam regs_t REGS_RST = '{
    acc:      '0,
    k:        '0,
    s:        '0,
    rfd_in:   1'b1,
    dav_out_: 1'b1
  };

endpackage

// File: rtl/quad_accumulator.sv
// Sums N_SAMPLES consecutive bit-count words between two four-phase
// handshakes (active-low dav / active-high rfd on both sides).
module quad_accumulator
  import quad_accumulator_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [C_W-1:0] c,
  input  logic           dav_in_,
  output logic           rfd_in,
  output logic [S_W-1:0] s,
  output logic           dav_out_,
  input  logic           rfd_out
);

  state_t state;
  state_t state_next;
  regs_t  regs;
  regs_t  regs_next;
  logic   last_sample;

  assign last_sample = (regs.k == K_W'(N_SAMPLES));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WAIT_DAV;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each state waits for one edge of the partner handshake.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_DAV: if (!dav_in_) state_next = ACK_IN;
      ACK_IN:   if (dav_in_)  state_next = last_sample ? PUT_OUT : WAIT_DAV;
      PUT_OUT:  if (!rfd_out) state_next = REL_OUT;
      REL_OUT:  if (rfd_out)  state_next = WAIT_DAV;
      default:  state_next = WAIT_DAV;
    endcase
  end

  // Output logic: next values of the registered datapath and handshake lines.
  always_comb begin
    regs_next = regs;
    case (state)
      WAIT_DAV: begin
        // c is captured only here, on the way into ACK_IN.
        if (!dav_in_) begin
          regs_next.acc    = regs.acc + S_W'(c);
          regs_next.k      = regs.k + K_W'(1);
          regs_next.rfd_in = 1'b0;
        end
      end
      ACK_IN: begin
        if (dav_in_) begin
          if (last_sample) begin
            // s and dav_out_ update on the same edge, so s is valid when dav_out_ falls.
            regs_next.s        = regs.acc;
            regs_next.dav_out_ = 1'b0;
          end else begin
            regs_next.rfd_in = 1'b1;
          end
        end
      end
      PUT_OUT: begin
        if (!rfd_out) regs_next.dav_out_ = 1'b1;
      end
      REL_OUT: begin
        if (rfd_out) begin
          regs_next.acc    = '0;
          regs_next.k      = '0;
          regs_next.rfd_in = 1'b1;
        end
      end
      default: regs_next = regs;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= REGS_RST;
    end else begin
      regs <= regs_next;
    end
  end

  assign rfd_in   = regs.rfd_in;
  assign s        = regs.s;
  assign dav_out_ = regs.dav_out_;

endmodule

// File: tb/tb_quad_accumulator.sv
// Directed bench for quad_accumulator: upstream driver tasks, a downstream
// responder with programmable release delay, and an output capture queue.
module tb_quad_accumulator;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic [2:0] c        = 3'd0;
  logic       dav_in_  = 1'b1;
  logic       rfd_in;
  logic [4:0] s;
  logic       dav_out_;
  logic       rfd_out  = 1'b1;

  int errors = 0;
  int checks = 0;

  int         ds_hold  = 0;
  int         low_cnt  = 0;
  logic       prev_dav = 1'b1;
  logic [4:0] outs[$];

  always #5 clock = ~clock;

  quad_accumulator #(.N_SAMPLES(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .c        (c),
    .dav_in_  (dav_in_),
    .rfd_in   (rfd_in),
    .s        (s),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out)
  );

  // Capture s at every falling edge of dav_out_.
  always @(negedge clock) begin
    if (prev_dav === 1'b1 && dav_out_ === 1'b0) outs.push_back(s);
    prev_dav = dav_out_;
  end

  // Downstream: take data as soon as offered, hold rfd_out low ds_hold cycles.
  always @(negedge clock) begin
    if (reset) begin
      rfd_out = 1'b1;
      low_cnt = 0;
    end else if (rfd_out && !dav_out_) begin
      rfd_out = 1'b0;
      low_cnt = 0;
    end else if (!rfd_out) begin
      if (dav_out_ && low_cnt >= ds_hold) rfd_out = 1'b1;
      else low_cnt++;
    end
  end

  // One upstream word; dav_in_ stays low 'hold' extra cycles, c is scrambled after capture.
  task automatic send_word(input logic [2:0] v, input int hold);
    int n;
    n = 0;
    while (rfd_in !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    if (rfd_in !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_rdy: rfd_in=%b want 1 (timeout)", rfd_in);
    end
    c = v; dav_in_ = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (rfd_in !== 1'b0 && n < 200);
    if (rfd_in !== 1'b0) begin
      checks++; errors++;
      $display("FAIL send_ack: rfd_in=%b want 0 (timeout)", rfd_in);
    end
    repeat (hold) @(negedge clock);
    c = 3'($urandom); dav_in_ = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rfd_in === 1'b1 && dav_out_ === 1'b1 && rfd_out === 1'b1) && n < 300) begin
      @(negedge clock); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_idle: rfd_in=%b dav_out_=%b rfd_out=%b (timeout)", rfd_in, dav_out_, rfd_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (rfd_in !== 1'b1) begin errors++; $display("FAIL rst_rfd_in: got %b want 1", rfd_in); end
    checks++; if (dav_out_ !== 1'b1) begin errors++; $display("FAIL rst_dav_out: got %b want 1", dav_out_); end
    checks++; if (s !== 5'd0) begin errors++; $display("FAIL rst_s: got %0d want 0", s); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (rfd_in !== 1'b1) begin errors++; $display("FAIL rel_rfd_in: got %b want 1", rfd_in); end
    checks++; if (dav_out_ !== 1'b1) begin errors++; $display("FAIL rel_dav_out: got %b want 1", dav_out_); end
    checks++; if (s !== 5'd0) begin errors++; $display("FAIL rel_s: got %0d want 0", s); end
    @(negedge clock);
  endtask

  task automatic test_basic();
    outs.delete();
    send_word(3'd0, 0);
    send_word(3'd4, 0);
    send_word(3'd1, 0);
    send_word(3'd4, 0);
    // Two clocks after the last dav_in_ fall, with dav_in_ already back high.
    checks++; if (dav_out_ !== 1'b0) begin errors++; $display("FAIL basic_latency: dav_out_=%b want 0", dav_out_); end
    checks++; if (s !== 5'd9) begin errors++; $display("FAIL basic_s_at_dav: got %0d want 9", s); end
    wait_idle();
    checks++; if (outs.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", outs.size()); end
    checks++; if (outs.size() < 1 || outs[0] !== 5'd9) begin errors++; $display("FAIL basic_sum: got %0d want 9", outs.size() ? outs[0] : 5'd0); end
  endtask

  task automatic test_stream();
    int vals[16] = '{0, 4, 1, 4, 2, 3, 0, 1, 4, 4, 4, 4, 1, 2, 1, 0};
    int exp_sum[4];
    outs.delete();
    for (int g = 0; g < 4; g++) begin
      exp_sum[g] = 0;
      for (int j = 0; j < 4; j++) exp_sum[g] += vals[4*g + j];
    end
    for (int i = 0; i < 16; i++) send_word(3'(vals[i]), i % 3);
    wait_idle();
    checks++; if (outs.size() !== 4) begin errors++; $display("FAIL stream_count: got %0d want 4", outs.size()); end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (outs.size() <= g || outs[g] !== 5'(exp_sum[g])) begin
        errors++;
        $display("FAIL stream_sum%0d: got %0d want %0d", g, outs.size() > g ? outs[g] : 5'd0, exp_sum[g]);
      end
    end
  endtask

  task automatic test_slow();
    logic bad;
    int   n;
    outs.delete();
    ds_hold = 10;
    send_word(3'd2, 1);
    send_word(3'd2, 1);
    send_word(3'd2, 1);
    send_word(3'd2, 0);
    checks++; if (s !== 5'd8 || dav_out_ !== 1'b0) begin errors++; $display("FAIL slow_out: s=%0d dav_out_=%b want 8/0", s, dav_out_); end
    // Upstream eagerly offers the next word while downstream holds rfd_out low.
    c = 3'd1; dav_in_ = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rfd_in !== 1'b0 || s !== 5'd8) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL slow_hold: rfd_in=%b s=%0d want 0 and 8 throughout", rfd_in, s); end
    n = 0;
    while (rfd_in !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    checks++; if (rfd_in !== 1'b1 || rfd_out !== 1'b1 || dav_out_ !== 1'b1) begin
      errors++; $display("FAIL slow_release: rfd_in=%b rfd_out=%b dav_out_=%b want 1/1/1", rfd_in, rfd_out, dav_out_);
    end
    @(negedge clock);
    checks++; if (rfd_in !== 1'b0) begin errors++; $display("FAIL slow_accept: rfd_in=%b want 0", rfd_in); end
    c = 3'd7; dav_in_ = 1'b1;
    @(negedge clock);
    ds_hold = 0;
    send_word(3'd2, 0);
    send_word(3'd3, 0);
    send_word(3'd0, 0);
    wait_idle();
    checks++; if (outs.size() !== 2) begin errors++; $display("FAIL slow_count: got %0d want 2", outs.size()); end
    checks++; if (outs.size() < 2 || outs[1] !== 5'd6) begin errors++; $display("FAIL slow_next_sum: got %0d want 6", outs.size() > 1 ? outs[1] : 5'd0); end
  endtask

  task automatic test_max();
    outs.delete();
    for (int i = 0; i < 4; i++) send_word(3'd7, 0);
    wait_idle();
    checks++; if (outs.size() < 1 || outs[0] !== 5'd28) begin errors++; $display("FAIL max_sum: got %0d want 28", outs.size() ? outs[0] : 5'd0); end
    send_word(3'd5, 0);
    send_word(3'd6, 1);
    send_word(3'd7, 0);
    send_word(3'd5, 2);
    wait_idle();
    checks++; if (outs.size() < 2 || outs[1] !== 5'd23) begin errors++; $display("FAIL odd_sum: got %0d want 23", outs.size() > 1 ? outs[1] : 5'd0); end
  endtask

  task automatic test_reset_mid();
    outs.delete();
    send_word(3'd4, 0);
    c = 3'd4; dav_in_ = 1'b0;
    @(negedge clock);
    checks++; if (rfd_in !== 1'b0) begin errors++; $display("FAIL mid_pre: rfd_in=%b want 0", rfd_in); end
    #3 reset = 1'b1;
    #1;
    checks++; if (rfd_in !== 1'b1) begin errors++; $display("FAIL mid_rst_rfd_in: got %b want 1", rfd_in); end
    checks++; if (dav_out_ !== 1'b1) begin errors++; $display("FAIL mid_rst_dav_out: got %b want 1", dav_out_); end
    checks++; if (s !== 5'd0) begin errors++; $display("FAIL mid_rst_s: got %0d want 0", s); end
    dav_in_ = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send_word(3'd1, 0);
    wait_idle();
    checks++; if (outs.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", outs.size()); end
    checks++; if (outs.size() < 1 || outs[0] !== 5'd4) begin errors++; $display("FAIL mid_sum: got %0d want 4", outs.size() ? outs[0] : 5'd0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_slow();
    test_max();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
